// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter for the register-bank write bus, with bounded lock.
// Picks one of four requesters per edge and drives the registered bus, one-hot write enable and grant.
module reg_bus_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREG     = 12,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [3:0]            lock,
  input  logic [4*ADDR_W-1:0]   addr,
  input  logic [4*WIDTH-1:0]    data,
  output logic [3:0]            grant,
  output logic [WIDTH-1:0]      bus_data,
  output logic [NREG-1:0]       write_en,
  output logic                  addr_err,
  output logic                  busy
);

  localparam int unsigned LCNT_W = $clog2(MAX_LOCK + 1);

  logic [1:0]        ptr_q, ptr_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              last_vld_q, last_vld_d;
  logic [1:0]        last_q, last_d;
  logic [3:0]        grant_q, grant_d;
  logic [WIDTH-1:0]  bus_data_q, bus_data_d;
  logic [NREG-1:0]   write_en_q, write_en_d;
  logic              addr_err_q, addr_err_d;
  logic              busy_q, busy_d;

  logic              held;
  logic              lock_cont;
  logic [3:0]        mask;
  logic [1:0]        idx;
  logic              win_vld;
  logic [1:0]        win;
  logic [ADDR_W-1:0] win_addr;
  logic [WIDTH-1:0]  win_data;

  // Winner selection; an expired locker steps aside unless it is alone.
  always_comb begin
    held      = last_vld_q && req[last_q] && lock[last_q];
    lock_cont = held && (lcnt_q < LCNT_W'(MAX_LOCK));
    mask      = req;
    idx       = '0;
    win_vld   = 1'b0;
    win       = ptr_q;
    if (held && !lock_cont && ((req & ~(4'b0001 << last_q)) != 4'b0000)) begin
      mask = req & ~(4'b0001 << last_q);
    end
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!win_vld && mask[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
    if (lock_cont) begin
      win_vld = 1'b1;
      win     = last_q;
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (win == 2'(i)) begin
        win_addr = addr[i*ADDR_W +: ADDR_W];
        win_data = data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    ptr_d      = ptr_q;
    lcnt_d     = '0;
    last_vld_d = 1'b0;
    last_d     = last_q;
    grant_d    = '0;
    bus_data_d = bus_data_q;
    write_en_d = '0;
    addr_err_d = 1'b0;
    busy_d     = 1'b0;
    if (win_vld) begin
      grant_d    = 4'b0001 << win;
      bus_data_d = win_data;
      busy_d     = 1'b1;
      last_vld_d = 1'b1;
      last_d     = win;
      if (lock_cont) begin
        lcnt_d = lcnt_q + LCNT_W'(1);
      end else begin
        ptr_d  = win + 2'd1;
        lcnt_d = lock[win] ? LCNT_W'(1) : '0;
      end
      // Out-of-range addresses are flagged, never aliased onto a register.
      if (32'(win_addr) < NREG) begin
        for (int r = 0; r < NREG; r++) begin
          write_en_d[r] = (32'(win_addr) == 32'(r));
        end
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      lcnt_q     <= '0;
      last_vld_q <= 1'b0;
      last_q     <= '0;
      grant_q    <= '0;
      bus_data_q <= '0;
      write_en_q <= '0;
      addr_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lcnt_q     <= lcnt_d;
      last_vld_q <= last_vld_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      bus_data_q <= bus_data_d;
      write_en_q <= write_en_d;
      addr_err_q <= addr_err_d;
      busy_q     <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign bus_data = bus_data_q;
  assign write_en = write_en_q;
  assign addr_err = addr_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_reg_bus_arbiter;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned NREG     = 12;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned MAX_LOCK = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [3:0]          req = '0;
  logic [3:0]          lock = '0;
  logic [4*ADDR_W-1:0] addr = '0;
  logic [4*WIDTH-1:0]  data = '0;
  logic [3:0]          grant;
  logic [WIDTH-1:0]    bus_data;
  logic [NREG-1:0]     write_en;
  logic                addr_err;
  logic                busy;

  int total = 0;
  int bad   = 0;

  // Model state: pointer, lock run length, last winner (-1 = none), held bus value.
  int               m_ptr, m_lcnt, m_last;
  logic [WIDTH-1:0] m_bus;
  logic [3:0]       e_grant;
  logic [NREG-1:0]  e_we;
  logic             e_err, e_busy;

  reg_bus_arbiter #(.WIDTH(WIDTH), .NREG(NREG), .ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .addr(addr), .data(data),
    .grant(grant), .bus_data(bus_data), .write_en(write_en), .addr_err(addr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lcnt = 0; m_last = -1; m_bus = '0;
    e_grant = '0; e_we = '0; e_err = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_edge();
    int w, excl, a;
    e_grant = '0; e_we = '0; e_err = 1'b0; e_busy = 1'b0;
    if (req == 4'b0000) begin
      m_last = -1; m_lcnt = 0;
      return;
    end
    w = -1;
    if (m_last >= 0 && req[m_last] && lock[m_last] && m_lcnt < MAX_LOCK) begin
      w = m_last;
      m_lcnt++;
    end else begin
      excl = -1;
      if (m_last >= 0 && req[m_last] && lock[m_last] && m_lcnt >= MAX_LOCK) begin
        for (int i = 0; i < 4; i++) if (i != m_last && req[i]) excl = m_last;
      end
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && req[(m_ptr + k) % 4] && ((m_ptr + k) % 4) != excl) w = (m_ptr + k) % 4;
      end
      m_ptr  = (w + 1) % 4;
      m_lcnt = lock[w] ? 1 : 0;
    end
    m_last  = w;
    e_grant = 4'(1 << w);
    m_bus   = data[w*WIDTH +: WIDTH];
    a       = int'(addr[w*ADDR_W +: ADDR_W]);
    if (a < NREG) e_we = NREG'(1) << a;
    else e_err = 1'b1;
    e_busy = 1'b1;
  endtask

  // One edge: model predicts, outputs sampled 1 time unit after the edge, back at negedge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, "_grant"}, 64'(grant), 64'(e_grant));
    chk({tag, "_bus"},   64'(bus_data), 64'(m_bus));
    chk({tag, "_we"},    64'(write_en), 64'(e_we));
    chk({tag, "_err"},   64'(addr_err), 64'(e_err));
    chk({tag, "_busy"},  64'(busy), 64'(e_busy));
    chk({tag, "_inv_g1h"}, 64'(grant & (grant - 4'd1)), 64'd0);
    chk({tag, "_inv_we1h"}, 64'(write_en & (write_en - NREG'(1))), 64'd0);
    chk({tag, "_inv_errwe"}, 64'(addr_err && (write_en != '0)), 64'd0);
    @(negedge clk);
  endtask

  task automatic set_rq(input int i, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    addr[i*ADDR_W +: ADDR_W] = a;
    data[i*WIDTH +: WIDTH]   = d;
  endtask

  logic [3:0] lock_pat;
  logic [3:0] exp_g;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_we", 64'(write_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(addr_err), 64'd0);
    chk("rst_bus", 64'(bus_data), 64'd0);
    reset = 1'b0;

    // Fairness with all four requesting.
    for (int i = 0; i < 4; i++) set_rq(i, ADDR_W'(i + 1), WIDTH'(16'h1000 * (i + 1) + i));
    req = 4'b1111; lock = 4'b0000;
    for (int n = 0; n < 5; n++) begin
      step("fair");
      exp_g = 4'b0001 << (n % 4);
      chk("fair_seq", 64'(grant), 64'(exp_g));
    end

    // Single write, then idle with bus held.
    req = 4'b0100; set_rq(2, 4'd5, 16'hA5A5);
    step("single");
    chk("single_grant", 64'(grant), 64'h4);
    chk("single_we", 64'(write_en), 64'h020);
    chk("single_bus", 64'(bus_data), 64'hA5A5);
    req = 4'b0000;
    step("idle");
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_bus", 64'(bus_data), 64'hA5A5);

    // Address error then the highest legal address.
    req = 4'b0001; set_rq(0, 4'd13, 16'h1234);
    step("aerr");
    chk("aerr_err", 64'(addr_err), 64'd1);
    chk("aerr_we", 64'(write_en), 64'd0);
    set_rq(0, 4'd11, 16'h4321);
    step("aok");
    chk("aok_we", 64'(write_en), 64'h800);
    chk("aok_err", 64'(addr_err), 64'd0);

    // Lock bound: 8 locked grants, one to the other requester, 8 more.
    req = 4'b0110; lock = 4'b0010;
    for (int n = 0; n < 17; n++) begin
      step("lock");
      exp_g = (n == 8) ? 4'b0100 : 4'b0010;
      chk("lock_seq", 64'(grant), 64'(exp_g));
    end

    // Sole locked requester never sees a gap.
    req = 4'b0010;
    for (int n = 0; n < 20; n++) begin
      step("sole");
      chk("sole_seq", 64'(grant), 64'h2);
    end

    // Asynchronous reset mid-burst.
    req = 4'b1111; lock = 4'b0000;
    step("burst");
    model_edge();
    @(posedge clk);
    #2;
    chk("pre_arst_busy", 64'(busy), 64'(e_busy));
    reset = 1'b1;
    #1;
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_we", 64'(write_en), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step("post_rst");
    chk("post_rst_grant", 64'(grant), 64'h1);

    // Random traffic with sticky lock patterns to exercise expiry.
    lock_pat = '0;
    for (int n = 0; n < 400; n++) begin
      if (n % 25 == 0) lock_pat = 4'($urandom);
      req  = 4'($urandom) | (($urandom_range(0, 3) != 0) ? lock_pat : 4'b0000);
      if ($urandom_range(0, 9) == 0) req = 4'b0000;
      lock = lock_pat;
      for (int i = 0; i < 4; i++) set_rq(i, ADDR_W'($urandom_range(0, 15)), WIDTH'($urandom));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the single internal write bus of the image-sampling processor's register bank between four requesters: control unit, ALU, memory interface and immediate path.
- Each cycle, picks one requester by round-robin with optional bounded lock.
- Drives the registered shared data bus and a one-hot write enable into the 16-bit write-enabled registers (IR, TY, etc.).
- Returns a grant pulse to the winning requester.

Parameters:
- WIDTH, 16, data bus width
- NREG, 12, number of registers on the bus; write_en width
- ADDR_W, 4, register address width per requester
- MAX_LOCK, 8, maximum consecutive locked grants before lock is overridden for one arbitration

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  4  per-requester write request, level; bit i = requester i
- lock  in  4  per-requester lock; meaningful only with req[i]
- addr  in  4*ADDR_W  flat; requester i address at [i*ADDR_W +: ADDR_W]
- data  in  4*WIDTH  flat; requester i data at [i*WIDTH +: WIDTH]
- grant  out  4  one-hot registered grant; high = data of that requester was accepted at the last edge
- bus_data  out  WIDTH  registered shared write data
- write_en  out  NREG  registered one-hot register write enable
- addr_err  out  1  registered pulse; granted address >= NREG
- busy  out  1  registered; high whenever any grant bit is high

Behaviour:
Reset:
- Async on reset high. All outputs go to 0 immediately.
- Round-robin pointer ptr = 0. Lock counter lcnt = 0. last = none.
- Reset mid-operation discards any in-flight write: write_en drops at once, no partial write.

Arbitration (evaluated combinationally, registered at every rising edge):
- No req bit set: grant, write_en, addr_err and busy become 0. bus_data holds its last value. ptr is unchanged. last = none, lcnt = 0.
- Lock continuation: applies if last = i, req[i] = 1, lock[i] = 1 and lcnt < MAX_LOCK. Winner = i, lcnt increments, ptr is unchanged.
- Otherwise: winner = first set req bit scanning ptr, ptr+1, … modulo 4. Then ptr <= winner+1 mod 4. lcnt <= 1 if lock[winner], else 0.
- Lock expiry: when lock is overridden because lcnt reached MAX_LOCK, the previous locker is excluded from this arbitration if any other req is set. If it is the sole requester, it wins and lcnt restarts at 1.

Outputs at the edge (latency 1):
- grant <= onehot(winner).
- bus_data <= data[winner].
- If addr[winner] < NREG: write_en <= onehot(addr[winner]). Otherwise write_en <= 0 and addr_err <= 1.
- busy <= 1.

Timing:
- Destination registers capture bus_data on the edge after write_en asserts.
- Total req-to-register latency is 2 edges.

Handshake:
- req is sampled every edge; each sampled-high edge is a distinct write.
- A requester wanting a single write deasserts req during the cycle its grant is high.
- A req held high after its grant is a new request; rotation lets other requesters in first.

Width rules:
- addr is unsigned.
- No truncation: addresses 12–15 (default config) are errors and never alias onto registers.

Invariants:
- grant is one-hot or zero.
- write_en is one-hot or zero and is zero whenever grant is zero.
- addr_err is never high together with write_en.

Test Plan:
1. Reset: hold reset, then release. All outputs 0. Assert reset asynchronously mid-burst (between edges): grant, write_en and busy drop to 0 immediately; after release, first grant goes to requester 0 if requesting.
2. Single write: req=0100, addr2=5, data2=0xA5A5 for one edge. Next cycle grant=0100, write_en=0x020, bus_data=0xA5A5, busy=1. The following cycle all are 0 with bus_data still 0xA5A5.
3. Fairness: req=1111 held, lock=0, distinct addr/data per requester. Grants cycle 0001, 0010, 0100, 1000, 0001, with matching write_en and bus_data each cycle.
4. Address error: req=0001, addr0=13, data0=0x1234. grant=0001, write_en=0, addr_err=1 for one cycle, busy=1. Then req=0001, addr0=11: write_en bit 11 set, addr_err=0.
5. Lock bound: req=0110, lock=0010 held, ptr=1. grant=0010 for exactly 8 consecutive cycles, then 0100 once, then 0010 for 8 more.
6. Lock sole requester: req=0010, lock=0010 held for 20 cycles. grant=0010 every cycle with no gap.
